down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
Loadable down-counter and timer, the count-down counterpart of the team's free-running up counter. It is loaded with a start value, decrements on enabled cycles and flags terminal count when it reaches 0. It can then stop, or auto-reload for periodic ticks. Peripheral timers and delay generators use it as their timebase.

Parameters:
WIDTH, 4, counter and load-value width in bits.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
load  input  1  load strobe; captures load_val.
load_val  input  WIDTH  start and reload value.
en  input  1  count enable; decrement only when high.
auto_reload  input  1  1 = reload at terminal count, 0 = stop at terminal count.
out  output  WIDTH  current count, registered.
zero  output  1  combinational, out == 0.
tc  output  1  registered one-cycle terminal-count pulse.
busy  output  1  high while in COUNT state.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port rst, and takes effect on the rising edge of clk.
- Priority on each edge: rst > load > en.
- Reset:
  - out = 0, tc = 0, busy = 0, zero = 1.
  - Internal reload register = 0, state = IDLE.
  - Applies from any state, including mid-count. Any pending tc is dropped.
- States: IDLE and COUNT.
  - busy = (state == COUNT).
  - tc is a registered output and defaults to 0 every cycle unless set below.
- load = 1, in any state:
  - out <= load_val and reload register <= load_val.
  - tc <= 0, and en is ignored that cycle.
  - Next state: COUNT if load_val != 0, otherwise IDLE.
- IDLE:
  - out holds its value and en is ignored.
  - Only load leaves IDLE.
- COUNT with en = 0: out holds and tc <= 0.
- COUNT with en = 1 and out > 1: out <= out - 1.
- COUNT with en = 1 and out == 1 (terminal), tc <= 1 in both cases:
  - auto_reload = 0: out <= 0 and state <= IDLE.
  - auto_reload = 1: out <= reload register and state stays COUNT.
  - Period is therefore N enabled cycles for reload value N.
  - With reload value 1, tc is high on every enabled cycle.
- auto_reload is sampled only at the terminal edge. Changing it mid-count is legal.
- tc timing:
  - High for exactly the one cycle following the terminal edge.
  - Non-reload mode: that cycle has out = 0.
  - Reload mode: that cycle has out = reload value.
- Simultaneous load and terminal: load wins and tc stays 0.
- Arithmetic:
  - Unsigned and WIDTH bits.
  - No underflow is possible, because out never decrements from 0.
  - load_val = 2^WIDTH - 1 gives the maximum period of 15 for WIDTH = 4.
- Latency:
  - load to visible out: 1 cycle.
  - load of N to tc with en held high: tc is high in the cycle following the N-th rising edge after the load edge.

Test Plan:
1. Reset: hold rst high for 2 cycles with load = 1 and load_val = 9 -> out = 0, zero = 1, busy = 0, tc = 0; load is ignored.
2. One-shot: load 5, auto_reload = 0, en = 1 -> out reads 5, 4, 3, 2, 1, 0 on successive cycles. tc is high only in the out = 0 cycle, busy falls with it, and out then stays 0 in IDLE with en still high.
3. Auto-reload with gating: load 3, auto_reload = 1, en toggling 1, 0, 1, 1, ... -> out decrements only on en = 1 cycles. Sequence 3, 2, 2, 1, 3, 2, 1, 3, ... with tc = 1 in each cycle showing the reloaded 3. Then set auto_reload = 0 mid-count -> the next terminal goes to 0 and IDLE.
4. Edge values:
   - load 0 -> IDLE, zero = 1, no tc.
   - load 1 with auto_reload = 1 and en = 1 -> out stays 1 and tc is high every cycle.
   - load 15 with WIDTH = 4 -> tc after 15 enabled cycles.
5. Collisions:
   - load 7 on the same edge as terminal (out = 1, en = 1) -> out = 7, tc = 0, busy = 1.
   - rst asserted mid-count at out = 4 -> next cycle out = 0 and IDLE; a later load restarts normally.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts enabled cycles from a loaded value to zero,
// pulses tc at terminal count, then either stops or reloads for periodic ticks.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // State register; reset drops any pending tc and the stored reload value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state logic: load outranks counting, so a load on the terminal edge
    // suppresses that tc.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? COUNT : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COUNT: begin
                    if (en) begin
                        // "<= 1" also guards the unreachable case of counting from 0.
                        if (count_q <= WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign out  = count_q;
    assign zero = (count_q == '0);
    assign tc   = tc_q;
    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed and randomized checks of down_counter_timer against constant
// expectations and a cycle-level behavioural model.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             tc;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: remaining count, period, running flag, tc pulse.
    int m_count  = 0;
    int m_period = 0;
    bit m_run    = 0;
    bit m_tc     = 0;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .out         (out),
        .zero        (zero),
        .tc          (tc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic chk_dut(input string tag, input int e_out, input int e_tc, input int e_busy);
        chk({tag, ".out"}, int'(out), e_out);
        chk({tag, ".zero"}, int'(zero), (e_out == 0) ? 1 : 0);
        chk({tag, ".tc"}, int'(tc), e_tc);
        chk({tag, ".busy"}, int'(busy), e_busy);
    endtask

    // Apply inputs for one edge, advance the model with the same inputs,
    // then compare DUT against the model 1 time unit after the edge.
    task automatic cyc(input logic r, input logic l, input int v, input logic e, input logic a);
        rst         = r;
        load        = l;
        load_val    = WIDTH'(v);
        en          = e;
        auto_reload = a;
        @(posedge clk);
        #1;
        m_tc = 0;
        if (r) begin
            m_count = 0; m_period = 0; m_run = 0;
        end else if (l) begin
            m_count = v; m_period = v; m_run = (v != 0);
        end else if (m_run && e) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (a) m_count = m_period;
                else begin m_count = 0; m_run = 0; end
            end else begin
                m_count = m_count - 1;
            end
        end
        chk_dut("model", m_count, int'(m_tc), int'(m_run));
    endtask

    initial begin
        int seq_out[7];
        int seq_tc[7];
        int seq_en[7];
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;

        // 1. Reset with load asserted: load is ignored.
        cyc(1, 1, 9, 0, 0);
        cyc(1, 1, 9, 0, 0);
        chk_dut("reset", 0, 0, 0);

        // 2. One-shot from 5.
        cyc(0, 1, 5, 1, 0);
        chk_dut("oneshot_load", 5, 0, 1);
        seq_out = '{4, 3, 2, 1, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk_dut("oneshot", seq_out[i], (i == 4) ? 1 : 0, (i < 4) ? 1 : 0);
        end

        // 3. Auto-reload of 3 with gated enable.
        cyc(0, 1, 3, 0, 1);
        chk_dut("reload_load", 3, 0, 1);
        seq_en  = '{1, 0, 1, 1, 1, 1, 1};
        seq_out = '{2, 2, 1, 3, 2, 1, 3};
        seq_tc  = '{0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, seq_en[i][0], 1);
            chk_dut("reload", seq_out[i], seq_tc[i], 1);
        end
        // auto_reload dropped mid-count: next terminal stops.
        cyc(0, 0, 0, 1, 0); chk_dut("reload_off", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); chk_dut("reload_off", 1, 0, 1);
        cyc(0, 0, 0, 1, 0); chk_dut("reload_off_tc", 0, 1, 0);

        // 4. Edge values.
        cyc(0, 1, 0, 1, 1); chk_dut("load0", 0, 0, 0);
        cyc(0, 0, 0, 1, 1); chk_dut("load0_hold", 0, 0, 0);
        cyc(0, 1, 1, 1, 1); chk_dut("load1", 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1);
            chk_dut("period1", 1, 1, 1);
        end
        cyc(0, 1, 15, 1, 0); chk_dut("load15", 15, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk_dut("max_period", 15 - i, (i == 15) ? 1 : 0, (i < 15) ? 1 : 0);
        end

        // 5. Collisions.
        cyc(0, 1, 2, 1, 0);
        cyc(0, 0, 0, 1, 0); chk_dut("coll_pre", 1, 0, 1);
        cyc(0, 1, 7, 1, 0); chk_dut("load_vs_tc", 7, 0, 1);
        cyc(0, 1, 6, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0); chk_dut("mid_pre_rst", 4, 0, 1);
        cyc(1, 0, 0, 1, 0); chk_dut("mid_rst", 0, 0, 0);
        cyc(0, 1, 2, 1, 0); chk_dut("restart", 2, 0, 1);
        cyc(0, 0, 0, 1, 0); chk_dut("restart", 1, 0, 1);
        cyc(0, 0, 0, 1, 0); chk_dut("restart_tc", 0, 1, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
